// File: rtl/en_delay_line.sv
// Clock-enabled WIDTH x DEPTH delay line with per-stage valid bits and a saturating fill count.
// Optional combinational tap port is compiled in when EN_DELAY_LINE_TAP_EN is defined.
module en_delay_line #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CW = $clog2(DEPTH + 1),
   localparam int unsigned TW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
`ifdef EN_DELAY_LINE_TAP_EN
   input  logic [TW-1:0]    tap_sel,
   output logic [WIDTH-1:0] tap,
   output logic             tap_valid,
`endif
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   output logic [CW-1:0]    fill
);

   localparam logic [CW-1:0] FillMax = CW'(DEPTH);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [CW-1:0]    fill_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
         vld_q  <= '0;
         fill_q <= '0;
      end else if (clr) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
         vld_q  <= '0;
         fill_q <= '0;
      end else if (en) begin
         // d is only sampled here, so an X on d while disabled never reaches state
         stage_q[0] <= d;
         vld_q[0]   <= 1'b1;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
            vld_q[i]   <= vld_q[i-1];
         end
         if (fill_q < FillMax) fill_q <= fill_q + 1'b1;
      end
   end

   assign q       = stage_q[DEPTH-1];
   assign q_valid = vld_q[DEPTH-1];
   assign fill    = fill_q;

`ifdef EN_DELAY_LINE_TAP_EN
   // Compare-based select so out-of-range tap_sel naturally yields zeros
   always_comb begin
      tap       = '0;
      tap_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (tap_sel == TW'(i)) begin
            tap       = stage_q[i];
            tap_valid = vld_q[i];
         end
      end
   end
`endif

endmodule
